// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: uart_lite register map, status bits, response codes and tx-arbiter FSM states.
package uart_lite_pkg;
  localparam logic [31:0] ADDR_RX = 32'h00;
  localparam logic [31:0] ADDR_TX = 32'h04;
  localparam logic [31:0] ADDR_STATUS = 32'h08;
  localparam logic [31:0] ADDR_CONTROL = 32'h0C;
  localparam int STATUS_TXEMPTY = 2;
  localparam int STATUS_TXFULL = 3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_GAP, S_WR, S_WR_RESP} state_t;
endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_i+1 modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [1:0]   last_i,
  output logic         any_o,
  output logic [1:0]   grant_o
);
  logic [3:0] v;
  logic [1:0] idx;
  always_comb begin
    v = 4'(valid_i);
    idx = '0;
    any_o = 1'b0;
    grant_o = last_i;
    // descending scan so the nearest candidate after last_i is written last
    for (int k = N; k >= 1; k--) begin
      idx = 2'((int'(last_i) + k) % N);
      if (v[idx]) begin
        any_o = 1'b1;
        grant_o = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin byte scheduler driving uart_lite over AXI-Lite (poll STATUS, write TX).
// Optional drop-on-timeout behaviour is enabled with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int POLL_GAP = 16,
  parameter int POLL_LIMIT = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 m_awvalid_o,
  output logic [31:0]          m_awaddr_o,
  output logic                 m_wvalid_o,
  output logic [31:0]          m_wdata_o,
  output logic [3:0]           m_wstrb_o,
  input  logic                 m_awready_i,
  input  logic                 m_wready_i,
  input  logic                 m_bvalid_i,
  input  logic [1:0]           m_bresp_i,
  output logic                 m_bready_o,
  output logic                 m_arvalid_o,
  output logic [31:0]          m_araddr_o,
  input  logic                 m_arready_i,
  input  logic                 m_rvalid_i,
  input  logic [31:0]          m_rdata_i,
  input  logic [1:0]           m_rresp_i,
  output logic                 m_rready_o,
  output logic                 busy_o,
  output logic [1:0]           grant_o,
  output logic                 err_o
);
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, arb_grant;
  logic [7:0] byte_q, byte_d, gap_q, gap_d;
  logic [12:0] poll_q, poll_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d, data_ext;
  logic [3:0] wstrb_q, wstrb_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic bready_q, bready_d, busy_q, busy_d, err_q, err_d;
  logic arb_any, retry, ack, limit_hit, unused_rdata;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid_i(req_valid_i),
    .last_i (grant_q),
    .any_o  (arb_any),
    .grant_o(arb_grant)
  );
  assign data_ext = 32'(req_data_i);
  assign limit_hit = TIMEOUT_EN && (int'(poll_q) + 1 >= POLL_LIMIT);
  assign unused_rdata = ^{m_rdata_i[31:STATUS_TXEMPTY+1], m_rdata_i[STATUS_TXEMPTY-1:0]};
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    byte_d = byte_q;
    gap_d = gap_q;
    poll_d = poll_q;
    araddr_d = araddr_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    awvalid_d = 1'b0;
    wvalid_d = 1'b0;
    retry = 1'b0;
    ack = 1'b0;
    err_d = 1'b0;
    case (state_q)
      // the idle cycle carrying a ready pulse is skipped so a stale valid is never re-granted
      S_IDLE: if (arb_any && !(|req_ready_q)) begin
        state_d = S_RD_ADDR;
        grant_d = arb_grant;
        byte_d = data_ext[{arb_grant, 3'b000} +: 8];
        poll_d = '0;
      end
      S_RD_ADDR: if (m_arready_i) state_d = S_RD_DATA;
      S_RD_DATA: if (m_rvalid_i) begin
        if (m_rresp_i == RESP_OKAY && m_rdata_i[STATUS_TXEMPTY]) begin
          state_d = S_WR;
          awvalid_d = 1'b1;
          wvalid_d = 1'b1;
          awaddr_d = ADDR_TX;
          wdata_d = {24'b0, byte_q};
          wstrb_d = 4'h1;
        end else retry = 1'b1;
      end
      S_GAP: begin
        state_d = (gap_q == '0) ? S_RD_ADDR : S_GAP;
        gap_d = (gap_q == '0) ? gap_q : gap_q - 8'd1;
      end
      S_WR: begin
        awvalid_d = awvalid_q & ~m_awready_i;
        wvalid_d = wvalid_q & ~m_wready_i;
        state_d = (awvalid_d || wvalid_d) ? S_WR : S_WR_RESP;
      end
      S_WR_RESP: if (m_bvalid_i) begin
        ack = m_bresp_i == RESP_OKAY;
        retry = m_bresp_i != RESP_OKAY;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (retry) begin
      poll_d = (poll_q == '1) ? poll_q : poll_q + 13'd1;
      ack = limit_hit;
      err_d = limit_hit;
      state_d = limit_hit ? S_IDLE : S_GAP;
      gap_d = 8'(POLL_GAP);
    end
    if (state_d == S_RD_ADDR) araddr_d = ADDR_STATUS;
    req_ready_d = ack ? NUM_REQ'(1) << grant_q : '0;
    arvalid_d = state_d == S_RD_ADDR;
    rready_d = state_d == S_RD_DATA;
    bready_d = state_d == S_WR_RESP;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      grant_q <= 2'(NUM_REQ - 1);
      byte_q <= '0;
      gap_q <= '0;
      poll_q <= '0;
      araddr_q <= '0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      req_ready_q <= '0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      byte_q <= byte_d;
      gap_q <= gap_d;
      poll_q <= poll_d;
      araddr_q <= araddr_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      req_ready_q <= req_ready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign req_ready_o = req_ready_q;
  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o = araddr_q;
  assign m_rready_o = rready_q;
  assign m_awvalid_o = awvalid_q;
  assign m_awaddr_o = awaddr_q;
  assign m_wvalid_o = wvalid_q;
  assign m_wdata_o = wdata_q;
  assign m_wstrb_o = wstrb_q;
  assign m_bready_o = bready_q;
  assign busy_o = busy_q;
  assign grant_o = grant_q;
  assign err_o = err_q;
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin transmit scheduler that shares one `uart_lite` instance between several byte producers (CPU console, debug monitor, trace). It is the single AXI-Lite master on the UART configuration port. For each granted byte it polls STATUS until TXEMPTY is set, writes the TX register, checks the write response, and only then acknowledges the requester. It sits between the producers and `uart_lite`; producers never touch the UART registers directly.

## Interface
- `NUM_REQ`, 2: number of requesters (legal range 2..4).
- `POLL_GAP`, 16: idle cycles between consecutive STATUS polls (legal range 0..255).
- `POLL_LIMIT`, 4096: maximum STATUS polls per byte; used only with `UART_TX_ARB_TIMEOUT_EN`.
- `clk_i`  in  1  system clock; the single clock of the block.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester byte pending.
- `req_data_i`  in  8*NUM_REQ  byte for requester i, in bits [8i+7:8i].
- `req_ready_o`  out  NUM_REQ  one-cycle pulse: byte of requester i is consumed.
- `m_awvalid_o`/`m_awaddr_o[31:0]`/`m_wvalid_o`/`m_wdata_o[31:0]`/`m_wstrb_o[3:0]`  out  AXI-Lite write address and data channels toward `uart_lite`.
- `m_awready_i`, `m_wready_i`, `m_bvalid_i`, `m_bresp_i[1:0]`  in  write handshakes and write response.
- `m_bready_o`  out  1  write response ready.
- `m_arvalid_o`/`m_araddr_o[31:0]`  out  read address channel.
- `m_arready_i`, `m_rvalid_i`, `m_rdata_i[31:0]`, `m_rresp_i[1:0]`  in  read handshakes and read data.
- `m_rready_o`  out  1  read data ready.
- `busy_o`  out  1  a byte is in flight.
- `grant_o`  out  2  index of the current or last granted requester.
- `err_o`  out  1  one-cycle pulse on a dropped byte (timeout build only; tied to 0 otherwise).

## Operation
- Requester protocol: hold `req_valid_i` and the data stable until `req_ready_o` pulses. The byte is latched at grant.
- Arbitration is round-robin. The search starts at `last_grant+1` mod NUM_REQ; `last_grant` resets to NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE: if any valid, latch the byte and grant, go to RD_ADDR.
  - RD_ADDR: `m_arvalid_o`=1, `m_araddr_o`=0x08. On `m_arready_i`, go to RD_DATA.
  - RD_DATA: `m_rready_o`=1. On `m_rvalid_i`:
    - if `m_rresp_i`==OKAY and `m_rdata_i[2]`==1 (TXEMPTY), go to WR.
    - otherwise go to GAP.
  - GAP: count POLL_GAP cycles, then go to RD_ADDR.
  - WR: `m_awvalid_o`=`m_wvalid_o`=1, `m_awaddr_o`=0x04, `m_wdata_o`={24'b0,byte}, `m_wstrb_o`=4'h1. Drive both valids together. Drop each valid independently once its ready is seen; when both are seen, go to WR_RESP.
  - WR_RESP: `m_bready_o`=1. On `m_bvalid_i`:
    - OKAY: pulse `req_ready_o[grant]`, go to IDLE.
    - SLVERR: go to GAP and re-poll; the byte is retained.
- `m_araddr_o` stays stable until the R handshake. `m_awaddr_o` and `m_wdata_o` stay stable until the B handshake, because `uart_lite` samples them after the ready.
- A requester whose valid drops after grant is still served; its ready pulse is harmless.
- The poll counter is 13 bits and saturates; it clears at grant.

## Timing
- Reset values: all `m_*valid_o`, `m_rready_o`, and `m_bready_o` are 0. Addresses, data, `m_wstrb_o`, `req_ready_o`, `busy_o`, and `err_o` are 0. `grant_o` resets to NUM_REQ-1. The FSM resets to IDLE.
- Reset mid-transaction abandons the transaction immediately; the byte is lost and no ready pulse is issued.
- Grant to RD_ADDR takes 1 cycle. When the UART is idle, `req_ready_o` pulses no earlier than 6 cycles after grant (with `uart_lite` one-cycle ready latency).
- Back-to-back bytes: the next grant is the cycle after `req_ready_o`.
- All outputs are registered. Only one AXI channel group is active at a time; reads and writes never overlap.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined: after POLL_LIMIT polls without TXEMPTY (or POLL_LIMIT SLVERR retries), the byte is dropped. In that cycle `req_ready_o[grant]` and `err_o` pulse together, and the FSM returns to IDLE.
- Not defined: polling continues indefinitely, and `err_o` is constant 0.

## Structure
- A shared package `uart_lite_pkg` holds:
  - register offsets RX 0x00, TX 0x04, STATUS 0x08, CONTROL 0x0C.
  - STATUS bit indices TXEMPTY=2 and TXFULL=3.
  - response codes OKAY=2'b00 and SLVERR=2'b10.
  - the FSM state enum.
- One sub-module, `rr_arbiter`: combinational next-grant from the valid vector and `last_grant`.

## Test plan
- Single byte: req0 sends 0x41, UART idle → one STATUS read then write to 0x04 with wdata 0x41 and wstrb 4'h1; `req_ready_o[0]` pulses once.
- Contention: req0=0x11 and req1=0x22 asserted in the same cycle, both held → TX writes occur in order 0x11, 0x22, and a repeat of req0 follows req1.
- Busy UART: STATUS returns 0x08 three times, then 0x04 → four reads spaced by POLL_GAP+ cycles, then a single write.
- SLVERR: first write returns bresp 2'b10 → re-poll, byte rewritten, `req_ready_o` pulses only after the OKAY write.
- Timeout build: POLL_LIMIT=4 and STATUS always 0x08 → exactly 4 reads, then `err_o` and `req_ready_o` pulse in the same cycle, with no write.
- Reset: assert `rst_ni`=0 during WR_RESP → all outputs at reset values asynchronously; after release, a new request proceeds normally.
